one_hot_encoder: RTL and testbench
==================================

// Module: one_hot_encoder
// PURPOSE
// - Registered binary-to-one-hot encoder: a 4-bit index in, a 16-bit one-hot word out.
// - Exactly one output bit is set, at the position given by the index.
// - Used as a decode stage in front of select, enable or mux-control fabric.
// - One clock domain; output is registered with 1-cycle latency.
// PARAMETERS
// - IN_W   default 4    width of binary index input ip
// - OUT_W  default 16   width of one-hot output op; fixed to 2**IN_W, not overridable independently
// PORTS
// - clk       input   1      rising-edge clock
// - rst       input   1      synchronous, active-high reset
// - ip_valid  input   1      qualifies ip this cycle
// - ip        input   IN_W   binary index, 0..2**IN_W-1
// - op        output  OUT_W  registered one-hot result
// - op_valid  output  1      high when op holds a freshly encoded value
// BEHAVIOUR
// - One clock, clk; reset rst is synchronous and active-high.
// - All state updates on the rising edge of clk only. No combinational path from input to output.
// - Reset: rst=1 at an edge -> op=0, op_valid=0. Reset has priority over ip_valid.
//   - Reset mid-stream discards the input sampled on that edge.
// - Encode (rst=0, ip_valid=1): op <= 1 << ip and op_valid <= 1. Latency is exactly 1 cycle.
//   - Bit k of op is set iff ip==k.
// - Idle (rst=0, ip_valid=0): op_valid <= 0; op is cleared to 0 (default build).
// - Throughput: one encode per cycle. Back-to-back valids give back-to-back results with no bubbles.
// - Boundaries:
//   - ip=0 -> op=16'h0001.
//   - ip=15 -> op=16'h8000.
//   - No wrap or saturation: every ip value in range is legal.
// - Invariant: whenever op_valid=1, op has exactly one bit set ($onehot).
//   - Outside reset and outside hold mode, op_valid=0 implies op=0.
// - An ip containing X/Z while ip_valid=1 is illegal. The output for it is undefined.
// CONFIGURATION
// - Macro ONE_HOT_ENCODER_HOLD_EN. When defined, op holds its last encoded value while ip_valid=0.
//   - op_valid still drops to 0 while held.
//   - Only rst clears op in this mode.
// - When not defined, op clears to 0 on any cycle with ip_valid=0 (default).
// TESTING
// - Reset: hold rst=1 for 2 cycles with ip_valid=1, ip=5 -> op=16'h0000, op_valid=0 after each edge.
// - Sweep: ip_valid=1, ip=0..15 on consecutive cycles -> one cycle later op=16'h0001, 16'h0002 ... 16'h8000.
//   - op_valid=1 throughout the sweep.
// - Idle: ip=7 valid, then ip_valid=0 with ip=3 -> op=16'h0080, then 16'h0000 with op_valid=0.
//   - With ONE_HOT_ENCODER_HOLD_EN, op stays 16'h0080 and op_valid=0.
// - Mid-stream reset: ip=9 valid with rst=1 on the same edge -> op=0, op_valid=0.
//   - Next edge with ip=9 valid and rst=0 -> op=16'h0200.
// - Invariant check: random ip/ip_valid for 1000 cycles.
//   - Every cycle with op_valid=1: $onehot(op) holds and op == 1 << (ip sampled one cycle earlier).

Source files
------------

// File: rtl/one_hot_encoder.sv
// Registered binary-to-one-hot decoder: IN_W-bit index in, 2**IN_W-bit one-hot word out, 1-cycle latency.
// Build option ONE_HOT_ENCODER_HOLD_EN: op keeps its last encoded value while ip_valid is low.
module one_hot_encoder #(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ip_valid,
  input  logic [IN_W-1:0]  ip,
  output logic [OUT_W-1:0] op,
  output logic             op_valid
);

  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [OUT_W-1:0] op_d, op_q;
  logic             op_valid_d, op_valid_q;

  always_comb begin
`ifdef ONE_HOT_ENCODER_HOLD_EN
    op_d = op_q;
`else
    op_d = '0;
`endif
    op_valid_d = 1'b0;
    if (ip_valid) begin
      op_d       = ONE << ip;
      op_valid_d = 1'b1;
    end
  end

  // Reset wins over a valid input sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      op_valid_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign op       = op_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_one_hot_encoder.sv
// Self-checking bench for one_hot_encoder: directed cases plus 1000 random cycles against a reference model.
module tb_one_hot_encoder;
  localparam int IN_W  = 4;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ip_valid;
  logic [IN_W-1:0]  ip;
  logic [OUT_W-1:0] op;
  logic             op_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what op should hold after the most recent edge.
  logic [OUT_W-1:0] exp_op = '0;
  logic             exp_vld = 1'b0;

  one_hot_encoder #(.IN_W(IN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ip_valid (ip_valid),
    .ip       (ip),
    .op       (op),
    .op_valid (op_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs, advance one edge, update the model and compare.
  task automatic step(input logic r, input logic v, input int idx, input string tag);
    rst      = r;
    ip_valid = v;
    ip       = IN_W'(idx);
    @(posedge clk);
    #1;
    if (r) begin
      exp_op  = '0;
      exp_vld = 1'b0;
    end else if (v) begin
      exp_op  = OUT_W'(2 ** idx);
      exp_vld = 1'b1;
    end else begin
`ifndef ONE_HOT_ENCODER_HOLD_EN
      exp_op  = '0;
`endif
      exp_vld = 1'b0;
    end
    check({tag, ".op"}, 32'(op), 32'(exp_op));
    check({tag, ".op_valid"}, 32'(op_valid), 32'(exp_vld));
    if (op_valid === 1'b1)
      check({tag, ".onehot"}, 32'($onehot(op)), 32'd1);
  endtask

  initial begin
    rst = 1'b1; ip_valid = 1'b1; ip = 4'd5;
    #1;

    // Reset dominates a valid input.
    step(1'b1, 1'b1, 5, "reset0");
    step(1'b1, 1'b1, 5, "reset1");

    // Full sweep, back-to-back; boundaries are 0 -> 0001 and 15 -> 8000.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, i, $sformatf("sweep%0d", i));
    check("sweep_last", 32'(op), 32'h8000);

    // Idle after a valid encode.
    step(1'b0, 1'b1, 7, "idle_enc");
    check("idle_enc_abs", 32'(op), 32'h0080);
    step(1'b0, 1'b0, 3, "idle_off");
`ifdef ONE_HOT_ENCODER_HOLD_EN
    check("idle_hold_abs", 32'(op), 32'h0080);
`else
    check("idle_clear_abs", 32'(op), 32'h0000);
`endif

    // Mid-stream reset discards the input on that edge.
    step(1'b0, 1'b1, 2, "mid_pre");
    step(1'b1, 1'b1, 9, "mid_rst");
    step(1'b0, 1'b1, 9, "mid_post");
    check("mid_post_abs", 32'(op), 32'h0200);

    // Random valid/idle traffic with occasional resets.
    for (int c = 0; c < 1000; c++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
